// File: rtl/evm_booth_arbiter_pkg.sv
// Shared definitions for the booth arbiter: state encoding and party code width.
package evm_arb_pkg;

    localparam int PARTY_W = 2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_COMMIT = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_COMMIT = ST_COMMIT,
        S_HOLD   = ST_HOLD
    } state_t;

    // Index width for a booth vector; never below one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/evm_booth_arbiter_if.sv
// Booth-side and counter-side signals of the arbiter, grouped as one bus.
interface evm_booth_arbiter_if #(
    parameter int NUM_BOOTHS = 4,
    parameter int CNT_W      = 8
);
    import evm_arb_pkg::*;

    logic                          poll_open;
    logic [NUM_BOOTHS-1:0]         booth_req;
    logic [PARTY_W*NUM_BOOTHS-1:0] booth_party;
    logic [NUM_BOOTHS-1:0]         booth_ack;
    logic                          incr_valid;
    logic [PARTY_W-1:0]            incr_party;
    logic                          busy;
    logic [CNT_W-1:0]              commit_count;

    modport slave (
        input  poll_open, booth_req, booth_party,
        output booth_ack, incr_valid, incr_party, busy, commit_count
    );

    modport master (
        output poll_open, booth_req, booth_party,
        input  booth_ack, incr_valid, incr_party, busy, commit_count
    );

endinterface

// File: rtl/evm_booth_arbiter_picker.sv
// Round-robin picker: first requester at or after rr_ptr, wrapping modulo N.
module evm_rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_rr_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_any_req
);
    logic [IDX_W-1:0] w_cand;

    // Scan offsets from the far end down so the nearest requester to rr_ptr wins.
    always_comb begin
        w_cand      = '0;
        o_grant_idx = '0;
        o_any_req   = |i_req;
        for (int k = N - 1; k >= 0; k--) begin
            w_cand = IDX_W'((int'(i_rr_ptr) + k) % N);
            if (i_req[w_cand]) begin
                o_grant_idx = w_cand;
            end
        end
        o_grant = o_any_req ? (N'(1) << o_grant_idx) : '0;
    end

endmodule

// File: rtl/evm_booth_arbiter.sv
// Booth arbiter: grants one booth commit at a time to the shared vote counter.
//
// state  | meaning
// IDLE   | waiting for a request while the poll is open
// COMMIT | one-cycle increment pulse and booth ack
// HOLD   | guard time before the next grant may be considered
module evm_booth_arbiter #(
    parameter int NUM_BOOTHS  = 4,
    parameter int HOLD_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    evm_booth_arbiter_if.slave bus
);
    import evm_arb_pkg::*;

    localparam int IDX_W = idx_w(NUM_BOOTHS);
    localparam int HC_W  = $clog2(HOLD_CYCLES + 1);

    logic                  r_rst_meta;
    logic                  r_rst_sync;
    logic                  w_rst_n;

    state_t                r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      r_rr_ptr;
    logic [HC_W-1:0]       r_hold_cnt;
    logic [NUM_BOOTHS-1:0] r_ack;
    logic                  r_incr_valid;
    logic [PARTY_W-1:0]    r_incr_party;
    logic                  r_busy;
    logic [CNT_W-1:0]      r_count;

    logic [NUM_BOOTHS-1:0] w_grant;
    logic [IDX_W-1:0]      w_grant_idx;
    logic                  w_any_req;
    logic [PARTY_W-1:0]    w_party_sel;

    // Reset asserts immediately and releases on a clock edge after two stages.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end

    assign w_rst_n = r_rst_sync;

    evm_rr_picker #(
        .N     (NUM_BOOTHS),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_req       (bus.booth_req),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any_req   (w_any_req)
    );

    // Party code of the booth the picker currently selects.
    always_comb begin
        w_party_sel = '0;
        for (int i = 0; i < NUM_BOOTHS; i++) begin
            if (w_grant_idx == IDX_W'(i)) begin
                w_party_sel = bus.booth_party[i*PARTY_W +: PARTY_W];
            end
        end
    end

    // Grant FSM; pulses are loaded at the grant edge so they appear during COMMIT.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_rr_ptr     <= '0;
            r_hold_cnt   <= '0;
            r_ack        <= '0;
            r_incr_valid <= 1'b0;
            r_incr_party <= '0;
            r_busy       <= 1'b0;
            r_count      <= '0;
        end else begin
            r_ack        <= '0;
            r_incr_valid <= 1'b0;
            r_incr_party <= '0;
            case (r_state)
                S_IDLE: begin
                    if (bus.poll_open && w_any_req) begin
                        r_state      <= S_COMMIT;
                        r_idx        <= w_grant_idx;
                        r_ack        <= w_grant;
                        r_incr_valid <= 1'b1;
                        r_incr_party <= w_party_sel;
                        r_busy       <= 1'b1;
                        if (r_count != '1) begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                S_COMMIT: begin
                    r_rr_ptr   <= (r_idx == IDX_W'(NUM_BOOTHS - 1)) ? '0 : r_idx + 1'b1;
                    r_hold_cnt <= HC_W'(HOLD_CYCLES - 1);
                    r_state    <= S_HOLD;
                end
                S_HOLD: begin
                    if (r_hold_cnt != '0) begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.booth_ack    = r_ack;
    assign bus.incr_valid   = r_incr_valid;
    assign bus.incr_party   = r_incr_party;
    assign bus.busy         = r_busy;
    assign bus.commit_count = r_count;

endmodule

// File: tb/tb_evm_booth_arbiter.sv
// Bench for the booth arbiter: directed scenarios plus a random phase, checked
// every cycle against a timeline model of grants, guard time and counter.
module tb_evm_booth_arbiter;
    import evm_arb_pkg::*;

    localparam int N  = 4;
    localparam int H  = 2;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    evm_booth_arbiter_if #(.NUM_BOOTHS(N), .CNT_W(CW)) bus ();

    evm_booth_arbiter #(
        .NUM_BOOTHS  (N),
        .HOLD_CYCLES (H),
        .CNT_W       (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Model: m_since = -1 when free, else cycles elapsed since the grant edge.
    int         m_since = -1;
    int         m_ptr   = 0;
    int         m_idx   = 0;
    logic [1:0] m_party = 2'd0;
    int         m_cnt   = 0;
    bit         auto_drop = 1'b0;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs();
        logic [31:0] e_ack;
        e_ack = (m_since == 0) ? (32'd1 << m_idx) : 32'd0;
        chk("booth_ack",    32'(bus.booth_ack),    e_ack);
        chk("incr_valid",   32'(bus.incr_valid),   (m_since == 0) ? 32'd1 : 32'd0);
        chk("incr_party",   32'(bus.incr_party),   (m_since == 0) ? 32'(m_party) : 32'd0);
        chk("busy",         32'(bus.busy),         (m_since >= 0) ? 32'd1 : 32'd0);
        chk("commit_count", 32'(bus.commit_count), 32'(m_cnt));
    endtask

    // One clock: advance the model with the inputs seen at the edge, then check.
    task automatic cyc();
        @(posedge clk);
        if (m_since < 0) begin
            if (bus.poll_open && (|bus.booth_req)) begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (bus.booth_req[c]) begin
                        m_idx = c;
                        break;
                    end
                end
                m_party = bus.booth_party[2*m_idx +: 2];
                m_ptr   = (m_idx + 1) % N;
                if (m_cnt < (1 << CW) - 1) m_cnt++;
                m_since = 0;
            end
        end else begin
            m_since++;
            if (m_since > H) m_since = -1;
        end
        #1;
        check_outs();
        if (auto_drop && m_since == 0) bus.booth_req[m_idx] = 1'b0;
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        bus.booth_req = '0;
        #1;
        m_since = -1;
        m_ptr   = 0;
        m_cnt   = 0;
        check_outs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) cyc();
    endtask

    initial begin
        int pulses;
        int last_t;

        bus.poll_open   = 1'b0;
        bus.booth_req   = '0;
        bus.booth_party = '0;
        #2;

        // Reset, then idle with the poll open and nothing requested.
        do_reset();
        bus.poll_open = 1'b1;
        repeat (5) cyc();

        // Reset asserted during COMMIT clears the pulses at once.
        bus.booth_req = 4'b0001;
        cyc();
        do_reset();
        repeat (5) cyc();

        // Single request from booth 2 with party 3.
        auto_drop       = 1'b1;
        bus.booth_party = 8'b00_11_00_00;
        bus.booth_req   = 4'b0100;
        repeat (8) cyc();

        // All booths held: strict round-robin, fixed spacing.
        do_reset();
        auto_drop       = 1'b0;
        bus.poll_open   = 1'b1;
        bus.booth_party = 8'b11_10_01_00;
        bus.booth_req   = 4'b1111;
        pulses = 0;
        last_t = 0;
        for (int t = 0; t < 19; t++) begin
            cyc();
            if (bus.incr_valid === 1'b1) begin
                chk("rr_order_ack", 32'(bus.booth_ack), 32'd1 << (pulses % N));
                chk("rr_order_party", 32'(bus.incr_party), 32'(pulses % N));
                if (pulses > 0) chk("rr_spacing", 32'(t - last_t), 32'(H + 2));
                last_t = t;
                pulses++;
            end
        end
        chk("rr_pulse_count", 32'(pulses), 32'd5);
        bus.booth_req = '0;
        repeat (4) cyc();

        // Poll closed: requests ignored; closing during COMMIT finishes that commit only.
        bus.poll_open = 1'b0;
        bus.booth_req = 4'b0010;
        repeat (20) cyc();
        bus.poll_open = 1'b1;
        cyc();
        bus.poll_open = 1'b0;
        repeat (10) cyc();
        bus.booth_req = '0;
        bus.poll_open = 1'b1;
        repeat (2) cyc();

        // Request withdrawn before it can be granted; party changed after latching.
        auto_drop     = 1'b1;
        bus.booth_req = 4'b0001;
        cyc();
        bus.booth_req[3] = 1'b1;
        cyc();
        bus.booth_req[3] = 1'b0;
        repeat (4) cyc();
        bus.booth_party = 8'b00_01_00_00;
        bus.booth_req   = 4'b0100;
        cyc();
        bus.booth_party = 8'b00_10_00_00;
        repeat (5) cyc();

        // Counter saturation.
        do_reset();
        auto_drop       = 1'b0;
        bus.poll_open   = 1'b1;
        bus.booth_party = 8'b01_11_10_00;
        bus.booth_req   = 4'b1111;
        repeat (260 * (H + 2)) cyc();
        chk("count_saturated", 32'(bus.commit_count), 32'hFF);
        bus.booth_req = '0;
        repeat (4) cyc();

        // Random traffic against the model.
        do_reset();
        auto_drop = 1'b1;
        for (int t = 0; t < 400; t++) begin
            bus.poll_open = ($urandom_range(0, 7) != 0);
            for (int b = 0; b < N; b++) begin
                if (!bus.booth_req[b]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        bus.booth_req[b] = 1'b1;
                        bus.booth_party[2*b +: 2] = 2'($urandom_range(0, 3));
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    bus.booth_req[b] = 1'b0;
                end
            end
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
